// File: rtl/cpu6502_pkg.sv
// Shared CPU definitions: stack-pull sequencer states, stack page default and PSR bit positions.
package cpu6502_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DUMMY,
    ST_PULL_P,
    ST_PULL_L,
    ST_PULL_H,
    ST_INC_PC
  } rh_state_e;

  localparam logic [7:0] STACK_PAGE_DEF = 8'h01;

  localparam int PSR_N = 7;
  localparam int PSR_V = 6;
  localparam int PSR_U = 5;
  localparam int PSR_B = 4;
  localparam int PSR_D = 3;
  localparam int PSR_I = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_C = 0;

  // A PSR pulled from the stack always reads U=1 and B=0.
  function automatic logic [7:0] pulled_psr(input logic [7:0] d);
    logic [7:0] r;
    r = d;
    r[PSR_U] = 1'b1;
    r[PSR_B] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/return_handler.sv
// RTI/RTS stack-pull sequencer: dummy read at S, then pulls PSR (RTI), PCL, PCH from S+1 upward.
module return_handler
  import cpu6502_pkg::*;
#(
  parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEF
) (
  input  logic        clk,
  input  logic        rst_x,
  input  logic        start_rti,
  input  logic        start_rts,
  input  logic [7:0]  mem_data_in,
  output logic [15:0] mem_addr,
  output logic        mem_read,
  input  logic [7:0]  rgf_s,
  output logic [7:0]  rgf_data,
  output logic        rgf_set_psr,
  output logic        rgf_set_pcl,
  output logic        rgf_set_pch,
  output logic        rgf_pulled,
  output logic        rgf_inc_pc,
  output logic        busy,
  output logic        done
);

  rh_state_e  state;
  logic [7:0] sp;
  logic       mode_rti;
  logic [7:0] sp_inc;

  assign sp_inc = sp + 8'd1;

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state    <= ST_IDLE;
      sp       <= 8'h00;
      mode_rti <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // RTI has priority when both requests arrive together.
          if (start_rti || start_rts) begin
            state    <= ST_DUMMY;
            mode_rti <= start_rti;
            sp       <= rgf_s;
          end
        end
        ST_DUMMY:  state <= mode_rti ? ST_PULL_P : ST_PULL_L;
        ST_PULL_P: begin
          sp    <= sp_inc;
          state <= ST_PULL_L;
        end
        ST_PULL_L: begin
          sp    <= sp_inc;
          state <= ST_PULL_H;
        end
        ST_PULL_H: begin
          sp    <= sp_inc;
          state <= mode_rti ? ST_IDLE : ST_INC_PC;
        end
        ST_INC_PC: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode the current state; rgf_data passes memory data through in the same cycle.
  always_comb begin
    mem_addr    = 16'h0000;
    mem_read    = 1'b0;
    rgf_data    = 8'h00;
    rgf_set_psr = 1'b0;
    rgf_set_pcl = 1'b0;
    rgf_set_pch = 1'b0;
    rgf_pulled  = 1'b0;
    rgf_inc_pc  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      ST_DUMMY: begin
        busy     = 1'b1;
        mem_read = 1'b1;
        mem_addr = {STACK_PAGE, sp};
      end
      ST_PULL_P: begin
        busy        = 1'b1;
        mem_read    = 1'b1;
        mem_addr    = {STACK_PAGE, sp_inc};
        rgf_pulled  = 1'b1;
        rgf_set_psr = 1'b1;
        rgf_data    = pulled_psr(mem_data_in);
      end
      ST_PULL_L: begin
        busy        = 1'b1;
        mem_read    = 1'b1;
        mem_addr    = {STACK_PAGE, sp_inc};
        rgf_pulled  = 1'b1;
        rgf_set_pcl = 1'b1;
        rgf_data    = mem_data_in;
      end
      ST_PULL_H: begin
        busy        = 1'b1;
        mem_read    = 1'b1;
        mem_addr    = {STACK_PAGE, sp_inc};
        rgf_pulled  = 1'b1;
        rgf_set_pch = 1'b1;
        rgf_data    = mem_data_in;
        done        = mode_rti;
      end
      ST_INC_PC: begin
        busy       = 1'b1;
        rgf_inc_pc = 1'b1;
        done       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
